// File: rtl/spi_flash_reader.sv
// Read-only SPI flash master: one Wishbone word read becomes a 0x03 READ of four
// bytes (mode 0, MSB first), returned little-endian. Writes are acked with zero data.
module spi_flash_reader #(
  parameter int          ADDR_W   = 22,
  parameter int          CLK_DIV  = 1,
  parameter logic [7:0]  READ_CMD = 8'h03
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_wb_cyc,
  input  logic              i_wb_stb,
  input  logic              i_wb_we,
  input  logic [ADDR_W-1:0] i_wb_addr,
  output logic              o_wb_stall,
  output logic              o_wb_ack,
  output logic [31:0]       o_wb_data,
  output logic              o_spi_cs_n,
  output logic              o_spi_sck,
  output logic              o_spi_mosi,
  input  logic              i_spi_miso
);

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);
  // The mandatory IDLE cycle before the next accept also counts toward CS-high time.
  localparam logic [DIV_W-1:0] GAP_LOAD = DIV_W'(2 * CLK_DIV - 2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_ACK   = 2'd2,
    S_GAP   = 2'd3
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [31:0]      r_tx, w_tx_nxt;
  logic [31:0]      r_rx, w_rx_nxt;
  logic [5:0]       r_bit, w_bit_nxt;
  logic [DIV_W-1:0] r_div, w_div_nxt;
  logic             r_high, w_high_nxt;
  logic             r_cs_n, w_cs_n_nxt;
  logic             r_sck, w_sck_nxt;
  logic             r_mosi, w_mosi_nxt;
  logic             r_ack, w_ack_nxt;
  logic             r_stall, w_stall_nxt;
  logic [31:0]      r_data, w_data_nxt;
  logic [23:0]      w_byte_addr;
  logic [31:0]      w_rx_shift;

  function automatic logic [31:0] byte_swap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  assign w_byte_addr = 24'({i_wb_addr, 2'b00});
  assign w_rx_shift  = {r_rx[30:0], i_spi_miso};

  // Next-state and next-output logic for the transfer sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_tx_nxt    = r_tx;
    w_rx_nxt    = r_rx;
    w_bit_nxt   = r_bit;
    w_div_nxt   = r_div;
    w_high_nxt  = r_high;
    w_cs_n_nxt  = r_cs_n;
    w_sck_nxt   = r_sck;
    w_mosi_nxt  = r_mosi;
    w_ack_nxt   = 1'b0;
    w_data_nxt  = r_data;
    case (r_state)
      S_IDLE: begin
        if (i_wb_cyc && i_wb_stb) begin
          if (i_wb_we) begin
            w_state_nxt = S_ACK;
            w_ack_nxt   = 1'b1;
            w_data_nxt  = 32'h0000_0000;
          end else begin
            w_state_nxt = S_SHIFT;
            w_tx_nxt    = {READ_CMD, w_byte_addr};
            w_bit_nxt   = 6'd63;
            w_div_nxt   = DIV_LOAD;
            w_high_nxt  = 1'b0;
            w_cs_n_nxt  = 1'b0;
            w_sck_nxt   = 1'b0;
            w_mosi_nxt  = READ_CMD[7];
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SHIFT: begin
        if (!i_wb_cyc) begin
          w_state_nxt = S_GAP;
          w_cs_n_nxt  = 1'b1;
          w_sck_nxt   = 1'b0;
          w_mosi_nxt  = 1'b0;
          w_div_nxt   = GAP_LOAD;
        end else if (r_div != {DIV_W{1'b0}}) begin
          w_div_nxt = r_div - DIV_W'(1);
        end else if (!r_high) begin
          w_high_nxt = 1'b1;
          w_sck_nxt  = 1'b1;
          w_div_nxt  = DIV_LOAD;
        end else begin
          // End of a bit slot: falling SCK, sample MISO, advance TX (zeros fill the RX half).
          w_high_nxt = 1'b0;
          w_sck_nxt  = 1'b0;
          w_div_nxt  = DIV_LOAD;
          w_rx_nxt   = w_rx_shift;
          w_tx_nxt   = {r_tx[30:0], 1'b0};
          w_mosi_nxt = r_tx[30];
          w_bit_nxt  = r_bit - 6'd1;
          if (r_bit == 6'd0) begin
            w_state_nxt = S_ACK;
            w_cs_n_nxt  = 1'b1;
            w_mosi_nxt  = 1'b0;
            w_ack_nxt   = 1'b1;
            w_data_nxt  = byte_swap(w_rx_shift);
          end else begin
            w_state_nxt = S_SHIFT;
          end
        end
      end
      S_ACK: begin
        w_state_nxt = S_GAP;
        w_div_nxt   = GAP_LOAD;
      end
      S_GAP: begin
        if (r_div == {DIV_W{1'b0}}) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_div_nxt = r_div - DIV_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cs_n_nxt  = 1'b1;
        w_sck_nxt   = 1'b0;
        w_mosi_nxt  = 1'b0;
      end
    endcase
    w_stall_nxt = (w_state_nxt != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_tx    <= 32'h0000_0000;
      r_rx    <= 32'h0000_0000;
      r_bit   <= 6'd0;
      r_div   <= {DIV_W{1'b0}};
      r_high  <= 1'b0;
      r_cs_n  <= 1'b1;
      r_sck   <= 1'b0;
      r_mosi  <= 1'b0;
      r_ack   <= 1'b0;
      r_stall <= 1'b0;
      r_data  <= 32'h0000_0000;
    end else begin
      r_state <= w_state_nxt;
      r_tx    <= w_tx_nxt;
      r_rx    <= w_rx_nxt;
      r_bit   <= w_bit_nxt;
      r_div   <= w_div_nxt;
      r_high  <= w_high_nxt;
      r_cs_n  <= w_cs_n_nxt;
      r_sck   <= w_sck_nxt;
      r_mosi  <= w_mosi_nxt;
      r_ack   <= w_ack_nxt;
      r_stall <= w_stall_nxt;
      r_data  <= w_data_nxt;
    end
  end

  assign o_wb_stall = r_stall;
  assign o_wb_ack   = r_ack;
  assign o_wb_data  = r_data;
  assign o_spi_cs_n = r_cs_n;
  assign o_spi_sck  = r_sck;
  assign o_spi_mosi = r_mosi;

endmodule

// File: tb/tb_spi_flash_reader.sv
// Scoreboard bench for spi_flash_reader: two instances (CLK_DIV=1 and 2), each with a
// behavioural flash model; stimulus pushes expectations, per-instance monitors compare.
module tb_spi_flash_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc_cnt = 0;
  int total = 0;
  int bad = 0;

  logic        rst[2];
  logic        wb_cyc[2];
  logic        wb_stb[2];
  logic        wb_we[2];
  logic [21:0] wb_addr[2];

  int          csf_q[2][$];
  int          csr_q[2][$];
  int          ack_c_q[2][$];
  logic [31:0] ack_d_q[2][$];
  logic [31:0] cmd_q[2][$];

  initial forever begin
    @(posedge clk);
    cyc_cnt++;
  end

  function automatic logic [7:0] fbyte(input logic [23:0] a);
    case (a)
      24'h000000: return 8'hDE;
      24'h000001: return 8'hAD;
      24'h000002: return 8'hBE;
      24'h000003: return 8'hEF;
      24'h000004: return 8'h11;
      24'h000005: return 8'h22;
      24'h000006: return 8'h33;
      24'h000007: return 8'h44;
      24'h000010: return 8'hA1;
      24'h000011: return 8'hB2;
      24'h000012: return 8'hC3;
      24'h000013: return 8'hD4;
      24'hFFFFFC: return 8'h01;
      24'hFFFFFD: return 8'h02;
      24'hFFFFFE: return 8'h03;
      24'hFFFFFF: return 8'h04;
      default:    return 8'h00;
    endcase
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int D = g + 1;
    logic        stall, ack, cs_n, sck, mosi, miso;
    logic [31:0] data;
    logic        rst_q;
    logic        prev_cs = 1'b1;
    logic        prev_sck = 1'b0;
    int          run = 0;
    int          cmd_seen = 0;
    int          cmd_seq = 0;
    int          n = 0;
    int          j = 0;
    int          ec = 0;
    logic [31:0] ed;
    logic [31:0] cmd;
    logic [7:0]  bt;

    spi_flash_reader #(.ADDR_W(22), .CLK_DIV(D), .READ_CMD(8'h03)) u_dut (
      .clk(clk), .rst(rst[g]),
      .i_wb_cyc(wb_cyc[g]), .i_wb_stb(wb_stb[g]), .i_wb_we(wb_we[g]), .i_wb_addr(wb_addr[g]),
      .o_wb_stall(stall), .o_wb_ack(ack), .o_wb_data(data),
      .o_spi_cs_n(cs_n), .o_spi_sck(sck), .o_spi_mosi(mosi), .i_spi_miso(miso)
    );

    // Flash model: captures command on SCK rises, presents read data after each rise.
    initial begin
      miso = 1'b0;
      cmd  = 32'h0;
      forever begin
        @(posedge sck or negedge cs_n);
        if (sck === 1'b0) begin
          n   = 0;
          cmd = 32'h0;
        end else if (cs_n === 1'b0) begin
          n++;
          if (n <= 32) cmd = {cmd[30:0], mosi};
          if (n == 32) cmd_seq++;
          if (n >= 33) begin
            j    = n - 33;
            bt   = fbyte(cmd[23:0] + 24'(j / 8));
            miso = bt[7 - (j % 8)];
          end
        end
      end
    end

    initial forever begin
      @(posedge clk);
      rst_q = rst[g];
    end

    // Monitor: every check against the scoreboard happens here, half a cycle after the edge.
    initial forever begin
      @(negedge clk);
      if (rst_q === 1'b0) begin
        total++;
        if ({cs_n, sck, mosi, ack, stall, data} !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0}) begin
          bad++;
          $display("FAIL reset_vals[%0d]: got cs_n=%b sck=%b mosi=%b ack=%b stall=%b data=%h, want 1 0 0 0 0 00000000",
                   g, cs_n, sck, mosi, ack, stall, data);
        end
      end
      if (ack === 1'b1) begin
        if (ack_c_q[g].size() == 0) begin
          total++; bad++;
          $display("FAIL ack_unexpected[%0d]: got ack at cycle %0d, want no ack", g, cyc_cnt);
        end else begin
          ec = ack_c_q[g].pop_front();
          ed = ack_d_q[g].pop_front();
          total++;
          if (cyc_cnt != ec) begin
            bad++;
            $display("FAIL ack_cycle[%0d]: got %0d, want %0d", g, cyc_cnt, ec);
          end
          total++;
          if (data !== ed) begin
            bad++;
            $display("FAIL ack_data[%0d]: got %h, want %h", g, data, ed);
          end
        end
      end
      if (ack_c_q[g].size() > 0 && cyc_cnt > ack_c_q[g][0]) begin
        total++; bad++;
        $display("FAIL ack_timeout[%0d]: got no ack by cycle %0d, want ack at %0d", g, cyc_cnt, ack_c_q[g][0]);
        ec = ack_c_q[g].pop_front();
        ed = ack_d_q[g].pop_front();
      end
      if (sck !== prev_sck) begin
        if (prev_cs === 1'b0) begin
          total++;
          if (run != D) begin
            bad++;
            $display("FAIL sck_phase[%0d]: got %0d cycles, want %0d at cycle %0d", g, run, D, cyc_cnt);
          end
        end
        run = 1;
      end else begin
        run++;
      end
      if (cs_n === 1'b0 && prev_cs === 1'b1) begin
        run = 1;
        total++;
        if (csf_q[g].size() == 0) begin
          bad++;
          $display("FAIL cs_fall[%0d]: got fall at %0d, want none", g, cyc_cnt);
        end else begin
          ec = csf_q[g].pop_front();
          if (ec != cyc_cnt) begin
            bad++;
            $display("FAIL cs_fall[%0d]: got %0d, want %0d", g, cyc_cnt, ec);
          end
        end
      end
      if (cs_n === 1'b1 && prev_cs === 1'b0) begin
        total++;
        if (csr_q[g].size() == 0) begin
          bad++;
          $display("FAIL cs_rise[%0d]: got rise at %0d, want none", g, cyc_cnt);
        end else begin
          ec = csr_q[g].pop_front();
          if (ec != cyc_cnt) begin
            bad++;
            $display("FAIL cs_rise[%0d]: got %0d, want %0d", g, cyc_cnt, ec);
          end
        end
      end
      if (csf_q[g].size() > 0 && cyc_cnt > csf_q[g][0]) begin
        total++; bad++;
        $display("FAIL cs_fall_timeout[%0d]: got none by %0d, want %0d", g, cyc_cnt, csf_q[g][0]);
        ec = csf_q[g].pop_front();
      end
      if (csr_q[g].size() > 0 && cyc_cnt > csr_q[g][0]) begin
        total++; bad++;
        $display("FAIL cs_rise_timeout[%0d]: got none by %0d, want %0d", g, cyc_cnt, csr_q[g][0]);
        ec = csr_q[g].pop_front();
      end
      if (cmd_seq != cmd_seen) begin
        cmd_seen = cmd_seq;
        total++;
        if (cmd_q[g].size() == 0) begin
          bad++;
          $display("FAIL cmd[%0d]: got %h, want no command", g, cmd);
        end else begin
          ed = cmd_q[g].pop_front();
          if (cmd !== ed) begin
            bad++;
            $display("FAIL cmd[%0d]: got %h, want %h", g, cmd, ed);
          end
        end
      end
      if (cs_n === 1'b0) begin
        total++;
        if (stall !== 1'b1) begin
          bad++;
          $display("FAIL stall_busy[%0d]: got %b, want 1 at cycle %0d", g, stall, cyc_cnt);
        end
      end
      prev_cs  = cs_n;
      prev_sck = sck;
    end
  end

  task automatic wait_to(input int c);
    while (cyc_cnt < c) @(negedge clk);
  endtask

  task automatic drive(input int id, input logic we, input logic [21:0] a);
    wb_cyc[id]  = 1'b1;
    wb_stb[id]  = 1'b1;
    wb_we[id]   = we;
    wb_addr[id] = a;
  endtask

  task automatic expect_rd(input int id, input logic [21:0] a, input logic [31:0] d, input int acc);
    int lat;
    lat = 128 * (id + 1);
    csf_q[id].push_back(acc);
    csr_q[id].push_back(acc + lat);
    ack_c_q[id].push_back(acc + lat);
    ack_d_q[id].push_back(d);
    cmd_q[id].push_back({8'h03, a, 2'b00});
  endtask

  task automatic rd(input int id, input logic [21:0] a, input logic [31:0] d, input int acc);
    drive(id, 1'b0, a);
    expect_rd(id, a, d, acc);
    wait_to(acc);
    wb_stb[id] = 1'b0;
  endtask

  int acc;
  int acc2;

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b0; wb_cyc[i] = 1'b0; wb_stb[i] = 1'b0; wb_we[i] = 1'b0; wb_addr[i] = 22'h0;
    end
    repeat (3) @(negedge clk);
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    @(negedge clk);

    // Single read of word 1 (bytes 0x4..0x7).
    acc = cyc_cnt + 1;
    rd(0, 22'h000001, 32'h44332211, acc);
    wait_to(acc + 140);

    // Write: ack in the cycle after accept, zero data, no SPI activity.
    acc = cyc_cnt + 1;
    drive(0, 1'b1, 22'h000005);
    ack_c_q[0].push_back(acc);
    ack_d_q[0].push_back(32'h0);
    wait_to(acc);
    wb_stb[0] = 1'b0;
    wb_we[0]  = 1'b0;
    wait_to(acc + 6);

    // Back-to-back reads with stb held high; second address wraps to 0xFFFFFC.
    acc  = cyc_cnt + 1;
    acc2 = acc + 131;
    drive(0, 1'b0, 22'h000000);
    expect_rd(0, 22'h000000, 32'hEFBEADDE, acc);
    expect_rd(0, 22'h3FFFFF, 32'h04030201, acc2);
    wait_to(acc);
    wb_addr[0] = 22'h3FFFFF;
    wait_to(acc2);
    wb_stb[0] = 1'b0;
    wait_to(acc2 + 140);

    // Abort in bit slot 40, then a fresh read two cycles after CS rises.
    acc = cyc_cnt + 1;
    drive(0, 1'b0, 22'h000004);
    csf_q[0].push_back(acc);
    csr_q[0].push_back(acc + 81);
    cmd_q[0].push_back(32'h03000010);
    wait_to(acc);
    wb_stb[0] = 1'b0;
    wait_to(acc + 80);
    wb_cyc[0] = 1'b0;
    wait_to(acc + 81);
    rd(0, 22'h000004, 32'hD4C3B2A1, acc + 83);
    wait_to(acc + 83 + 140);

    // Reset asserted in bit slot 20, then a normal read.
    acc = cyc_cnt + 1;
    drive(0, 1'b0, 22'h000001);
    csf_q[0].push_back(acc);
    csr_q[0].push_back(acc + 41);
    wait_to(acc);
    wb_stb[0] = 1'b0;
    wait_to(acc + 40);
    rst[0] = 1'b0;
    wait_to(acc + 41);
    rst[0]    = 1'b1;
    wb_cyc[0] = 1'b0;
    @(negedge clk);
    acc = cyc_cnt + 1;
    rd(0, 22'h000000, 32'hEFBEADDE, acc);
    wait_to(acc + 140);

    // CLK_DIV=2 instance: 2-cycle SCK phases, 256-cycle latency.
    acc = cyc_cnt + 1;
    rd(1, 22'h000001, 32'h44332211, acc);
    wait_to(acc + 280);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
